// File: rtl/oric_ram_arbiter.sv
// rtl/oric_ram_arbiter.sv - single-port main-RAM arbiter: CPU first, then clear engine, then tape FIFO.
module oric_ram_arbiter #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] CLR_VALUE  = 8'h00
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        cpu_cs,
   input  logic        cpu_we,
   input  logic [15:0] cpu_ad,
   input  logic [7:0]  cpu_d,
   output logic [7:0]  cpu_q,
   output logic        cpu_q_valid,
   input  logic        tape_wr,
   input  logic [15:0] tape_addr,
   input  logic [7:0]  tape_dout,
   output logic        tape_ready,
   output logic        tape_ovf,
   input  logic        clr_start,
   output logic        clr_busy,
   output logic [15:0] mem_ad,
   output logic [7:0]  mem_d,
   output logic        mem_we,
   output logic        mem_cs,
   input  logic [7:0]  mem_q
);

   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic {
      CLR_IDLE,
      CLR_RUN
   } clr_state_e;

   clr_state_e  state_q, state_d;
   logic [15:0] clr_cnt_q, clr_cnt_d;

   logic [15:0] fifo_ad_q [0:FIFO_DEPTH-1];
   logic [7:0]  fifo_dt_q [0:FIFO_DEPTH-1];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          tape_ready_q, tape_ready_d;
   logic          tape_ovf_q, tape_ovf_d;

   logic [15:0] mem_ad_q, mem_ad_d;
   logic [7:0]  mem_d_q, mem_d_d;
   logic        mem_we_q, mem_we_d;
   logic        mem_cs_q, mem_cs_d;

   logic        rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d;
   logic [7:0]  cpu_q_q, cpu_q_d;
   logic        cpu_q_valid_q, cpu_q_valid_d;

   logic grant_clr, pop, push, full;

   // Clear engine; a restart request overrides whatever the running clear was doing.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      grant_clr = 1'b0;
      case (state_q)
         CLR_IDLE: ;
         CLR_RUN: begin
            grant_clr = ~cpu_cs;
            if (grant_clr) begin
               if (clr_cnt_q == 16'hFFFF) begin
                  state_d = CLR_IDLE;
               end else begin
                  clr_cnt_d = clr_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = CLR_IDLE;
      endcase
      if (clr_start) begin
         state_d   = CLR_RUN;
         clr_cnt_d = '0;
      end
   end

   always_comb begin
      full       = (count_q == FULL_CNT);
      pop        = ~cpu_cs & (state_q == CLR_IDLE) & (count_q != '0);
      push       = tape_wr & (~full | pop);
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW + 1)'(1);
      end
      tape_ready_d = (count_d != FULL_CNT);
      tape_ovf_d   = tape_ovf_q;
      if (clr_start) begin
         tape_ovf_d = 1'b0;
      end else if (tape_wr && full && !pop) begin
         tape_ovf_d = 1'b1;
      end

      mem_cs_d = 1'b0;
      mem_we_d = 1'b0;
      mem_ad_d = mem_ad_q;
      mem_d_d  = mem_d_q;
      if (cpu_cs) begin
         mem_cs_d = 1'b1;
         mem_we_d = cpu_we;
         mem_ad_d = cpu_ad;
         mem_d_d  = cpu_d;
      end else if (grant_clr) begin
         mem_cs_d = 1'b1;
         mem_we_d = 1'b1;
         mem_ad_d = clr_cnt_q;
         mem_d_d  = CLR_VALUE;
      end else if (pop) begin
         mem_cs_d = 1'b1;
         mem_we_d = 1'b1;
         mem_ad_d = fifo_ad_q[rd_ptr_q];
         mem_d_d  = fifo_dt_q[rd_ptr_q];
      end

      // Read data leaves the RAM one edge after mem_* and is captured one edge later.
      rd_s1_d       = cpu_cs & ~cpu_we;
      rd_s2_d       = rd_s1_q;
      cpu_q_valid_d = rd_s2_q;
      cpu_q_d       = rd_s2_q ? mem_q : cpu_q_q;
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_ad_q[wr_ptr_q] <= tape_addr;
         fifo_dt_q[wr_ptr_q] <= tape_dout;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= CLR_IDLE;
         clr_cnt_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         tape_ready_q  <= 1'b1;
         tape_ovf_q    <= 1'b0;
         mem_ad_q      <= '0;
         mem_d_q       <= '0;
         mem_we_q      <= 1'b0;
         mem_cs_q      <= 1'b0;
         rd_s1_q       <= 1'b0;
         rd_s2_q       <= 1'b0;
         cpu_q_q       <= '0;
         cpu_q_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         tape_ready_q  <= tape_ready_d;
         tape_ovf_q    <= tape_ovf_d;
         mem_ad_q      <= mem_ad_d;
         mem_d_q       <= mem_d_d;
         mem_we_q      <= mem_we_d;
         mem_cs_q      <= mem_cs_d;
         rd_s1_q       <= rd_s1_d;
         rd_s2_q       <= rd_s2_d;
         cpu_q_q       <= cpu_q_d;
         cpu_q_valid_q <= cpu_q_valid_d;
      end
   end

   assign cpu_q       = cpu_q_q;
   assign cpu_q_valid = cpu_q_valid_q;
   assign tape_ready  = tape_ready_q;
   assign tape_ovf    = tape_ovf_q;
   assign clr_busy    = (state_q == CLR_RUN);
   assign mem_ad      = mem_ad_q;
   assign mem_d       = mem_d_q;
   assign mem_we      = mem_we_q;
   assign mem_cs      = mem_cs_q;

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// tb/tb_oric_ram_arbiter.sv - randomized and directed bench for oric_ram_arbiter against a queue-based model.
module tb_oric_ram_arbiter;

   localparam int DEPTH = 4;
   localparam logic [7:0] CLRV = 8'h00;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        cpu_cs, cpu_we;
   logic [15:0] cpu_ad;
   logic [7:0]  cpu_d;
   logic [7:0]  cpu_q;
   logic        cpu_q_valid;
   logic        tape_wr;
   logic [15:0] tape_addr;
   logic [7:0]  tape_dout;
   logic        tape_ready, tape_ovf;
   logic        clr_start, clr_busy;
   logic [15:0] mem_ad;
   logic [7:0]  mem_d;
   logic        mem_we, mem_cs;
   logic [7:0]  mem_q;

   always #5 clk_sys = ~clk_sys;

   oric_ram_arbiter #(.FIFO_DEPTH(DEPTH), .CLR_VALUE(CLRV)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_ad(cpu_ad), .cpu_d(cpu_d),
      .cpu_q(cpu_q), .cpu_q_valid(cpu_q_valid),
      .tape_wr(tape_wr), .tape_addr(tape_addr), .tape_dout(tape_dout),
      .tape_ready(tape_ready), .tape_ovf(tape_ovf),
      .clr_start(clr_start), .clr_busy(clr_busy),
      .mem_ad(mem_ad), .mem_d(mem_d), .mem_we(mem_we), .mem_cs(mem_cs),
      .mem_q(mem_q)
   );

   // Synchronous RAM seen by the DUT.
   bit [7:0] ram [0:65535];
   always @(posedge clk_sys) begin
      if (mem_cs) begin
         if (mem_we) ram[mem_ad] <= mem_d;
         else        mem_q <= ram[mem_ad];
      end
   end

   // Reference model: priority rule, FIFO as a queue, clear as an address counter.
   typedef struct packed { logic [15:0] a; logic [7:0] d; } tent_t;
   typedef struct packed { int due; logic [7:0] d; } rd_t;
   tent_t fq[$];
   rd_t   rq[$];
   bit [7:0] shadow [0:65535];
   int    cyc, m_cnt, n_cpu_busy;
   logic  m_cs, m_we, m_qv, m_rdy, m_ovf, m_busy;
   logic [15:0] m_ad;
   logic [7:0]  m_d, m_q;

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         fq.delete(); rq.delete();
         cyc = 0; m_cnt = 0;
         m_cs = 0; m_we = 0; m_ad = 0; m_d = 0; m_q = 0; m_qv = 0;
         m_rdy = 1; m_ovf = 0; m_busy = 0;
      end else begin
         tent_t t;
         cyc++;
         m_qv = 0;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            m_qv = 1; m_q = rq[0].d; void'(rq.pop_front());
         end
         m_cs = 0; m_we = 0;
         if (cpu_cs) begin
            m_cs = 1; m_we = cpu_we; m_ad = cpu_ad; m_d = cpu_d;
            if (m_busy) n_cpu_busy++;
            if (cpu_we) shadow[cpu_ad] = cpu_d;
            else rq.push_back('{due: cyc + 2, d: shadow[cpu_ad]});
         end else if (m_busy) begin
            m_cs = 1; m_we = 1; m_ad = m_cnt[15:0]; m_d = CLRV;
            shadow[m_cnt[15:0]] = CLRV;
            if (m_cnt == 65535) m_busy = 0;
            else m_cnt++;
         end else if (fq.size() > 0) begin
            t = fq.pop_front();
            m_cs = 1; m_we = 1; m_ad = t.a; m_d = t.d;
            shadow[t.a] = t.d;
         end
         if (tape_wr) begin
            if (fq.size() < DEPTH) fq.push_back('{a: tape_addr, d: tape_dout});
            else m_ovf = 1;
         end
         if (clr_start) begin
            m_busy = 1; m_cnt = 0; m_ovf = 0;
         end
         m_rdy = (fq.size() < DEPTH);
      end
   end

   int n_vec = 0, n_mis = 0;
   bit chk_en = 0, in_clr = 0;
   int n_busy = 0, n_seen = 0, n_tape_busy = 0, n_tape_after = 0;
   logic [15:0] last_clr_ad;
   bit clr_seen [0:65535];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk_sys);
      if (chk_en) begin
         logic [37:0] act, exp;
         act = {mem_cs, mem_we, mem_ad, mem_d, cpu_q, cpu_q_valid, tape_ready, tape_ovf, clr_busy};
         exp = {m_cs, m_we, m_ad, m_d, m_q, m_qv, m_rdy, m_ovf, m_busy};
         n_vec++;
         if (act !== exp) begin
            n_mis++;
            $display("FAIL cycle %0d: got cs/we/ad/d/q/qv/rdy/ovf/busy=%h expected %h", cyc, act, exp);
         end
         if (in_clr) begin
            if (clr_busy) n_busy++;
            if (mem_cs && mem_we && mem_d == CLRV) begin
               if (!clr_seen[mem_ad]) begin clr_seen[mem_ad] = 1; n_seen++; end
               last_clr_ad = mem_ad;
            end
            if (mem_cs && mem_we && mem_d != CLRV) begin
               if (clr_busy) n_tape_busy++;
               else n_tape_after++;
            end
         end
      end
      @(posedge clk_sys);
      #2;
   endtask

   initial begin
      int g0, k, nz, stale;
      reset_n = 0; cpu_cs = 0; cpu_we = 0; cpu_ad = 0; cpu_d = 0;
      tape_wr = 0; tape_addr = 0; tape_dout = 0; clr_start = 0;
      repeat (2) @(posedge clk_sys);
      #2;
      check("rst_mem_cs", 32'(mem_cs), 0);
      check("rst_tape_ready", 32'(tape_ready), 1);
      check("rst_cpu_q", 32'(cpu_q), 0);
      check("rst_mem_ad", 32'(mem_ad), 0);
      reset_n = 1; chk_en = 1;

      // CPU write then read at the same address.
      cpu_cs = 1; cpu_we = 1; cpu_ad = 16'h1234; cpu_d = 8'hA5;
      tick;
      check("wr_mem_we", 32'(mem_we), 1);
      check("wr_mem_ad", 32'(mem_ad), 32'h1234);
      cpu_we = 0;
      tick;
      cpu_cs = 0;
      tick;
      check("rd_valid_early", 32'(cpu_q_valid), 0);
      tick;
      check("rd_valid", 32'(cpu_q_valid), 1);
      check("rd_data", 32'(cpu_q), 32'hA5);

      // Fill FIFO behind CPU traffic, then push and pop in the same cycle while full.
      cpu_cs = 1; cpu_we = 0; cpu_ad = 16'h1234;
      for (int i = 0; i < 4; i++) begin
         tape_wr = 1; tape_addr = 16'h0400 + 16'(i); tape_dout = 8'h20 + 8'(i);
         tick;
      end
      check("full_ready", 32'(tape_ready), 0);
      cpu_cs = 0; tape_addr = 16'h0404; tape_dout = 8'h24;
      tick;
      tape_wr = 0;
      check("pp_ready", 32'(tape_ready), 0);
      check("pp_ovf", 32'(tape_ovf), 0);
      check("pp_head", 32'(mem_ad), 32'h0400);
      for (int i = 1; i < 5; i++) begin
         tick;
         check("pp_order", 32'(mem_ad), 32'h0400 + 32'(i));
      end

      // Overflow test.
      cpu_cs = 1;
      for (int i = 0; i < 4; i++) begin
         tape_wr = 1; tape_addr = 16'h0500 + 16'(i); tape_dout = 8'h10 + 8'(i);
         tick;
      end
      check("ovf_ready", 32'(tape_ready), 0);
      tape_addr = 16'h0505; tape_dout = 8'h99;
      tick;
      check("ovf_flag", 32'(tape_ovf), 1);
      tape_wr = 0; cpu_cs = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("drain_we", 32'(mem_we), 1);
         check("drain_ad", 32'(mem_ad), 32'h0500 + 32'(i));
         check("drain_d", 32'(mem_d), 32'h10 + 32'(i));
      end
      check("drain_ready", 32'(tape_ready), 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cpu_cs = ($urandom_range(0, 1) == 1); cpu_we = 1'($urandom_range(0, 1));
         cpu_ad = 16'($urandom_range(0, 255)); cpu_d = 8'($urandom);
         tape_wr = ($urandom_range(0, 2) == 0);
         tape_addr = 16'($urandom_range(0, 255)); tape_dout = 8'($urandom);
         tick;
      end
      cpu_cs = 0; tape_wr = 0;
      repeat (8) tick;

      // Clear, restart, then full clear with CPU reads and tape pushes.
      clr_start = 1; tick; clr_start = 0;
      repeat (200) tick;
      clr_start = 1; tick; clr_start = 0;
      g0 = n_cpu_busy; in_clr = 1;
      tick;
      check("restart_ad0", 32'(mem_ad), 0);
      check("restart_we", 32'(mem_we), 1);
      for (int i = 0; i < 900; i++) begin
         cpu_cs = (i % 3 == 0); cpu_we = 0; cpu_ad = 16'($urandom);
         tape_wr = (i == 10 || i == 20); tape_addr = 16'h0700 + 16'(i); tape_dout = 8'hC0 + 8'(i);
         tick;
      end
      cpu_cs = 0; tape_wr = 0;
      k = 0;
      while (clr_busy === 1'b1 && k < 70000) begin tick; k++; end
      check("clr_done", 32'(clr_busy), 0);
      repeat (5) tick;
      in_clr = 0;
      check("clr_len", 32'(n_busy), 32'(65536 + n_cpu_busy - g0));
      check("clr_coverage", 32'(n_seen), 65536);
      check("clr_last", 32'(last_clr_ad), 32'hFFFF);
      check("tape_in_busy", 32'(n_tape_busy), 0);
      check("tape_after", 32'(n_tape_after), 2);
      nz = 0;
      for (int a = 0; a < 65536; a++) if (ram[a] != 8'h00) nz++;
      check("ram_nonzero", 32'(nz), 2);

      // Reset in the middle of a clear with a pending FIFO.
      clr_start = 1; tick; clr_start = 0;
      for (int i = 0; i < 3; i++) begin
         tape_wr = 1; tape_addr = 16'h0800 + 16'(i); tape_dout = 8'h55; tick;
      end
      tape_wr = 0;
      repeat (20) tick;
      #1 reset_n = 0;
      #1;
      check("arst_busy", 32'(clr_busy), 0);
      check("arst_cs", 32'(mem_cs), 0);
      check("arst_we", 32'(mem_we), 0);
      check("arst_ad", 32'(mem_ad), 0);
      check("arst_d", 32'(mem_d), 0);
      check("arst_ready", 32'(tape_ready), 1);
      check("arst_ovf_qv", 32'({tape_ovf, cpu_q_valid}), 0);
      repeat (2) tick;
      reset_n = 1;
      stale = 0;
      repeat (10) begin tick; if (mem_cs !== 1'b0) stale++; end
      check("no_stale", 32'(stale), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/oric_ram_arbiter.md
# oric_ram_arbiter

Single-port main-RAM arbiter for the Oric core, running in the `clk_sys` domain. It shares one 64 KB synchronous RAM port between three requesters: the CPU/ULA bus, the TAP loader write stream, and a memory-clear engine used at power-up and on user reset. CPU accesses always win. Tape writes are buffered in a small FIFO, and the clear engine fills RAM in the idle slots.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: tape write FIFO entries; power of two, minimum 2.
- `CLR_VALUE`, 8'h00: byte written to every address by the clear engine.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_cs`  in  1  CPU access request; one access per cycle it is high.
- `cpu_we`  in  1  CPU write (1) or read (0); qualified by `cpu_cs`.
- `cpu_ad`  in  16  CPU address.
- `cpu_d`  in  8  CPU write data.
- `cpu_q`  out  8  CPU read data; holds its value between reads.
- `cpu_q_valid`  out  1  one-cycle pulse when `cpu_q` is updated.
- `tape_wr`  in  1  push a tape byte (address and data) into the FIFO.
- `tape_addr`  in  16  tape byte address.
- `tape_dout`  in  8  tape byte data.
- `tape_ready`  out  1  FIFO not full.
- `tape_ovf`  out  1  sticky flag: a push was attempted while the FIFO was full.
- `clr_start`  in  1  pulse that starts a full-RAM clear.
- `clr_busy`  out  1  clear in progress.
- `mem_ad`  out  16  RAM address, registered.
- `mem_d`  out  8  RAM write data, registered.
- `mem_we`  out  1  RAM write strobe, registered.
- `mem_cs`  out  1  RAM select, registered.
- `mem_q`  in  8  RAM read data; the RAM registers it one cycle after `mem_cs`.

## Operation
- Grant priority, evaluated every cycle: CPU, then clear engine (while `clr_busy`), then tape FIFO head. At most one grant per cycle.
- Granted request: its address, data and write strobe are registered onto `mem_*`, with `mem_cs` set to 1. With no grant, `mem_cs` and `mem_we` are 0 and `mem_ad`/`mem_d` hold their previous values.
- CPU read pipeline:
  - Edge E0 samples the request.
  - `mem_*` drive the RAM after E0, and the RAM samples at E1.
  - `cpu_q` captures `mem_q` at E2, and `cpu_q_valid` is high for the cycle following E2.
  - Reads are fully pipelined, so back-to-back CPU reads produce back-to-back valid pulses.
- CPU writes produce no `cpu_q_valid`.
- Tape FIFO:
  - Push when `tape_wr & tape_ready`. Pop when the tape source is granted.
  - A simultaneous push and pop is legal in any state, including full; when full the push is accepted only if a pop occurs that same cycle.
  - A push while full with no pop is dropped and sets `tape_ovf`.
  - The FIFO preserves order, and the tape source issues only writes.
- Clear engine, two states:
  - IDLE: `clr_start` moves to CLEAR, loads the counter with 0 and asserts `clr_busy`.
  - CLEAR: each clear grant writes `CLR_VALUE` at the counter address and increments the counter.
  - The grant at address 16'hFFFF moves to IDLE and deasserts `clr_busy`. The counter does not wrap.
  - While in CLEAR, the tape FIFO is not drained; it keeps accepting pushes up to full.
  - `clr_start` during CLEAR restarts the clear at address 0.
  - `clr_start` clears `tape_ovf`.
- Reset mid-operation: all state returns to reset values immediately, the FIFO is emptied, and the clear is aborted. A clear is not started automatically; the integrator pulses `clr_start` after reset.

## Timing
- Reset values:
  - `cpu_q`, `mem_ad`, `mem_d`: 0.
  - `cpu_q_valid`, `tape_ovf`, `clr_busy`, `mem_we`, `mem_cs`: 0.
  - `tape_ready`: 1.
  - FIFO pointers and count: 0. Clear FSM: IDLE.
- Latencies:
  - CPU request to `mem_*`: 1 cycle.
  - CPU read request to `cpu_q_valid`: 2 cycles.
  - Tape push to earliest RAM write: 1 cycle after the push edge (the pushed entry is the head and no CPU or clear request is pending).
- `clr_busy` goes high the cycle after `clr_start` is sampled. A clear with no CPU traffic takes exactly 65536 cycles.
- `tape_ready` is registered from the FIFO count and updates the cycle after a push or pop.
- Starvation: continuous `cpu_cs` blocks the tape and clear sources indefinitely. This is acceptable because the CPU bus leaves idle phases.

## Test plan
- Reset, then CPU write 8'hA5 at 16'h1234, then CPU read 16'h1234 → `mem_we`=1 with `mem_ad`=16'h1234 one cycle after the write request; for the read, `cpu_q_valid` pulses 2 cycles after the request with `cpu_q`=8'hA5.
- Push 4 tape bytes (16'h0500..16'h0503 = 8'h10..8'h13) while `cpu_cs` is held high, then push a 5th → `tape_ready`=0 and `tape_ovf`=1; release `cpu_cs` → four RAM writes in order on consecutive cycles; `tape_ready` returns to 1.
- With the FIFO full, push and pop in the same cycle → entry accepted, count stays 4, `tape_ovf` stays 0.
- `clr_start` with no other traffic → `clr_busy` high for 65536 cycles, every address written with 8'h00, last write at 16'hFFFF, then `clr_busy`=0.
- During a clear, insert CPU reads every 3rd cycle and 2 tape pushes → CPU reads still return their data at 2-cycle latency; tape writes occur only after `clr_busy` falls; the clear takes 65536 + (number of CPU grants) cycles.
- Assert `reset_n` low mid-clear with a non-empty FIFO → all outputs take their reset values asynchronously; after release, `mem_cs` stays 0 with no stale FIFO writes.
